// File: rtl/ps2_keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard port: register map, STATUS bit
// positions and the receive frame states.
package ps2_keyboard_pkg;

    localparam logic [15:0] REG_DATA   = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    localparam int unsigned ST_NONEMPTY = 0;
    localparam int unsigned ST_OVF      = 1;
    localparam int unsigned ST_PERR     = 2;
    localparam int unsigned ST_FERR     = 3;
    localparam int unsigned ST_FULL     = 4;
    localparam int unsigned ST_IE       = 7;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU-side I/O bus of the PS/2 keyboard port.
interface ps2_keyboard_if;
    logic [15:0] address;
    logic [7:0]  data_o;
    logic        we;
    logic        read;
    logic [7:0]  dout;
    logic        hit;
    logic        intr;

    modport master (
        output address, data_o, we, read,
        input  dout, hit, intr
    );

    modport slave (
        input  address, data_o, we, read,
        output dout, hit, intr
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host deframer: input synchronizer, clock glitch filter,
// 11-bit frame FSM with inactivity timeout.
module ps2_rx_frame
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 2500
) (
    input  logic       clock_25,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       perr,
    output logic       ferr
);

    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    sync_clk, sync_dat;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall, dat;

    rx_state_t     state, state_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          par, par_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          valid_n, perr_n, ferr_n;

    assign dat  = sync_dat[1];
    // The filtered clock flips on the FILTER-th consecutive differing sample;
    // a falling edge is recognised in that same cycle.
    assign fall = filt_clk && !sync_clk[1] && (filt_cnt == FW'(FILTER - 1));

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            sync_clk <= '1;
            sync_dat <= '1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            sync_clk <= {sync_clk[0], ps2_clk};
            sync_dat <= {sync_dat[0], ps2_dat};
            if (sync_clk[1] != filt_clk) begin
                if (filt_cnt == FW'(FILTER - 1)) begin
                    filt_clk <= sync_clk[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bitcnt     <= bitcnt_n;
            par        <= par_n;
            tmo        <= tmo_n;
            byte_valid <= valid_n;
            rx_byte    <= shift;
            perr       <= perr_n;
            ferr       <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        par_n    = par;
        tmo_n    = '0;
        valid_n  = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;
        if (state == IDLE) begin
            if (fall && !dat) begin
                state_n  = DATA;
                bitcnt_n = '0;
            end
        end else if (!fall) begin
            tmo_n = tmo + TW'(1);
            if (tmo == TW'(TIMEOUT - 1)) begin
                state_n = IDLE;
                ferr_n  = 1'b1;
                tmo_n   = '0;
            end
        end else begin
            case (state)
                DATA: begin
                    shift_n  = {dat, shift[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!dat)                ferr_n  = 1'b1;
                    else if (^{shift, par})  valid_n = 1'b1;
                    else                     perr_n  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard CPU port: scan-code FIFO, DATA/STATUS register decode and
// level interrupt request.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter logic [15:0] BASE    = 16'h0030,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 2500
) (
    input  logic           clock_25,
    input  logic           reset_n,
    input  logic           ps2_clk,
    input  logic           ps2_dat,
    ps2_keyboard_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] ADDR_DATA   = BASE + REG_DATA;
    localparam logic [15:0] ADDR_STATUS = BASE + REG_STATUS;

    logic          rx_valid, rx_perr, rx_ferr;
    logic [7:0]    rx_byte;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, push, pop, wr_st, sel_data, sel_status;
    logic          ovf, perr, ferr, ie;
    logic [7:0]    status;

    ps2_rx_frame #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clock_25   (clock_25),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .perr       (rx_perr),
        .ferr       (rx_ferr)
    );

    assign sel_data   = (bus.address == ADDR_DATA);
    assign sel_status = (bus.address == ADDR_STATUS);
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign pop        = bus.read && sel_data && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = rx_valid && (!full || pop);
    assign wr_st      = bus.we && sel_status;

    always_ff @(posedge clock_25) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ie     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            ovf  <= (rx_valid && full && !pop) || (ovf  && !(wr_st && bus.data_o[ST_OVF]));
            perr <= rx_perr || (perr && !(wr_st && bus.data_o[ST_PERR]));
            ferr <= rx_ferr || (ferr && !(wr_st && bus.data_o[ST_FERR]));
            if (wr_st) ie <= bus.data_o[ST_IE];
        end
    end

    always_comb begin
        status              = '0;
        status[ST_NONEMPTY] = !empty;
        status[ST_OVF]      = ovf;
        status[ST_PERR]     = perr;
        status[ST_FERR]     = ferr;
        status[ST_FULL]     = full;
        status[ST_IE]       = ie;
    end

    always_comb begin
        bus.dout = '0;
        if (sel_data && !empty) bus.dout = mem[rd_ptr];
        else if (sel_status)    bus.dout = status;
    end

    assign bus.hit  = sel_data || sel_status;
    assign bus.intr = ie && !empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: PS/2 frames driven bit by bit, results
// read back through the DATA/STATUS registers.
module tb_ps2_keyboard;

    localparam logic [15:0] BASE = 16'h0030;
    localparam logic [15:0] STAT = 16'h0031;

    logic clock_25 = 1'b0;
    logic reset_n  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_dat  = 1'b1;
    int   checks   = 0;
    int   fails    = 0;

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .BASE    (BASE),
        .DEPTH   (8),
        .FILTER  (8),
        .TIMEOUT (2500)
    ) dut (
        .clock_25 (clock_25),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .bus      (bus)
    );

    always #20 clock_25 = ~clock_25;

    task automatic tick(input int n);
        repeat (n) @(posedge clock_25);
        #1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        #2 d = bus.dout;
        tick(1);
        bus.read    = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
        bus.address = a;
        bus.data_o  = v;
        bus.we      = 1'b1;
        tick(1);
        bus.we      = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] d);
        bus.address = a;
        #2 d = bus.dout;
    endtask

    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_dat = b;
        if (glitch) begin
            tick(5);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(12);
        end else begin
            tick(20);
        end
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic stop, input logic glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
        ps2_bit((~^d) ^ bad_par, glitch);
        ps2_bit(stop, glitch);
        ps2_dat = 1'b1;
        tick(30);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        tick(4);
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL reset_status_in_reset got %h want 00", d); end
        checks++;
        reset_n = 1'b1;
        tick(2);
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL reset_status got %h want 00", d); end
        checks++;
        if (bus.intr !== 1'b0) begin fails++; $display("FAIL reset_intr got %b want 0", bus.intr); end
        checks++;
        if (bus.hit !== 1'b1) begin fails++; $display("FAIL hit_status got %b want 1", bus.hit); end
        checks++;
        peek(BASE, d);
        if (d !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", d); end
        checks++;
        peek(16'h0032, d);
        if (bus.hit !== 1'b0 || d !== 8'h00) begin
            fails++; $display("FAIL miss_decode hit %b dout %h want 0 00", bus.hit, d);
        end
        checks++;
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic       seen = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !seen; i++) begin
            peek(STAT, d);
            if (d[0]) seen = 1'b1;
            else tick(1);
        end
        if (!seen) begin fails++; $display("FAIL single_wait nonempty never set got 0 want 1"); end
        checks++;
        peek(STAT, d);
        if (d !== 8'h01) begin fails++; $display("FAIL single_status got %h want 01", d); end
        checks++;
        cpu_write(BASE, 8'hFF);
        cpu_read(BASE, d);
        if (d !== 8'h1C) begin fails++; $display("FAIL single_data got %h want 1c", d); end
        checks++;
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL single_status_after got %h want 00", d); end
        checks++;
    endtask

    task automatic test_intr;
        logic [7:0] d;
        cpu_write(STAT, 8'h80);
        if (bus.intr !== 1'b0) begin fails++; $display("FAIL intr_empty got %b want 0", bus.intr); end
        checks++;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        if (bus.intr !== 1'b1) begin fails++; $display("FAIL intr_first got %b want 1", bus.intr); end
        checks++;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        cpu_read(BASE, d);
        if (d !== 8'hF0) begin fails++; $display("FAIL intr_data0 got %h want f0", d); end
        checks++;
        if (bus.intr !== 1'b1) begin fails++; $display("FAIL intr_between got %b want 1", bus.intr); end
        checks++;
        cpu_read(BASE, d);
        if (d !== 8'h1C) begin fails++; $display("FAIL intr_data1 got %h want 1c", d); end
        checks++;
        if (bus.intr !== 1'b0) begin fails++; $display("FAIL intr_after got %b want 0", bus.intr); end
        checks++;
        peek(STAT, d);
        if (d !== 8'h80) begin fails++; $display("FAIL intr_status got %h want 80", d); end
        checks++;
        cpu_write(STAT, 8'h00);
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        peek(STAT, d);
        if (d !== 8'h13) begin fails++; $display("FAIL ovf_status got %h want 13", d); end
        checks++;
        for (int i = 1; i <= 8; i++) begin
            cpu_read(BASE, d);
            if (d !== 8'(i)) begin fails++; $display("FAIL ovf_data%0d got %h want %h", i, d, 8'(i)); end
            checks++;
        end
        cpu_read(BASE, d);
        if (d !== 8'h00) begin fails++; $display("FAIL ovf_empty_read got %h want 00", d); end
        checks++;
        peek(STAT, d);
        if (d !== 8'h02) begin fails++; $display("FAIL ovf_sticky got %h want 02", d); end
        checks++;
        cpu_write(STAT, 8'h02);
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL ovf_clear got %h want 00", d); end
        checks++;
    endtask

    task automatic test_errors;
        logic [7:0] d;
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        peek(STAT, d);
        if (d !== 8'h04) begin fails++; $display("FAIL perr_status got %h want 04", d); end
        checks++;
        cpu_write(STAT, 8'h04);
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL perr_clear got %h want 00", d); end
        checks++;
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        peek(STAT, d);
        if (d !== 8'h08) begin fails++; $display("FAIL ferr_stop got %h want 08", d); end
        checks++;
        cpu_write(STAT, 8'h08);
    endtask

    task automatic test_timeout;
        logic [7:0] d;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        ps2_dat = 1'b1;
        tick(3000);
        peek(STAT, d);
        if (d !== 8'h08) begin fails++; $display("FAIL timeout_ferr got %h want 08", d); end
        checks++;
        cpu_write(STAT, 8'h08);
        send_frame(8'h3A, 1'b0, 1'b1, 1'b0);
        cpu_read(BASE, d);
        if (d !== 8'h3A) begin fails++; $display("FAIL timeout_recover got %h want 3a", d); end
        checks++;
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL timeout_status got %h want 00", d); end
        checks++;
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(20);
        end
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        peek(STAT, d);
        if (d !== 8'h01) begin fails++; $display("FAIL glitch_status got %h want 01", d); end
        checks++;
        cpu_read(BASE, d);
        if (d !== 8'hA5) begin fails++; $display("FAIL glitch_data got %h want a5", d); end
        checks++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        cpu_write(STAT, 8'h80);
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        peek(STAT, d);
        if (d !== 8'h85) begin fails++; $display("FAIL pre_reset_status got %h want 85", d); end
        checks++;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_dat = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        reset_n = 1'b0;
        tick(3);
        if (bus.intr !== 1'b0) begin fails++; $display("FAIL midreset_intr got %b want 0", bus.intr); end
        checks++;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(20);
        peek(STAT, d);
        if (d !== 8'h00) begin fails++; $display("FAIL midreset_status got %h want 00", d); end
        checks++;
        peek(BASE, d);
        if (d !== 8'h00) begin fails++; $display("FAIL midreset_data got %h want 00", d); end
        checks++;
        send_frame(8'h42, 1'b0, 1'b1, 1'b0);
        cpu_read(BASE, d);
        if (d !== 8'h42) begin fails++; $display("FAIL midreset_recover got %h want 42", d); end
        checks++;
    endtask

    initial begin
        bus.address = '0;
        bus.data_o  = '0;
        bus.we      = 1'b0;
        bus.read    = 1'b0;
        test_reset();
        test_single();
        test_intr();
        test_overflow();
        test_errors();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
